// File: rtl/uart_pkg.sv
// Shared UART constants, arbiter state encoding and frame-length helper.
package uart_pkg;

   localparam int BPS_CNT         = 434;
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FRAME = 2'd2
   } arb_state_e;

   // Includes the 2-cycle edge-detect latency plus one spare cycle in uart_send.
   function automatic int frame_cycles(input int bps, input int gap_bits);
      return bps * (UART_FRAME_BITS + gap_bits) + 3;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_gnt, wrapping.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [LW-1:0]      last_gnt,
   output logic               valid,
   output logic [LW-1:0]      sel
);

   always_comb begin
      valid = 1'b0;
      sel   = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         int idx;
         idx = (int'(last_gnt) + off) % NUM_REQ;
         if (!valid && req[idx]) begin
            valid = 1'b1;
            sel   = LW'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_send among NUM_REQ byte producers;
// the frame is timed locally because uart_send exposes no busy flag.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int BPS_CNT  = uart_pkg::BPS_CNT,
   parameter int GAP_BITS = 1,
   parameter int EN_HOLD  = 4,
   parameter int LW       = $clog2(NUM_REQ)
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 arb_en,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 tx_byte_en,
   output logic [7:0]           tx_byte,
   output logic                 busy,
   output logic [LW-1:0]        last_gnt
);

   localparam int FRAME_CYCLES = frame_cycles(BPS_CNT, GAP_BITS);

   arb_state_e           state_q;
   logic [31:0]          cnt_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic                 tx_byte_en_q;
   logic [7:0]           tx_byte_q;
   logic                 busy_q;
   logic [LW-1:0]        last_gnt_q;

   logic                 pick_vld;
   logic [LW-1:0]        pick_sel;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .LW      (LW)
   ) u_pick (
      .req      (req),
      .last_gnt (last_gnt_q),
      .valid    (pick_vld),
      .sel      (pick_sel)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ack_q        <= '0;
         tx_byte_en_q <= 1'b0;
         tx_byte_q    <= 8'h00;
         busy_q       <= 1'b0;
         last_gnt_q   <= LW'(NUM_REQ - 1);
      end else begin
         case (state_q)
            IDLE: begin
               // req_data is sampled only here; later changes are ignored
               if (arb_en && pick_vld) begin
                  ack_q           <= '0;
                  ack_q[pick_sel] <= 1'b1;
                  tx_byte_q       <= req_data[8*pick_sel +: 8];
                  last_gnt_q      <= pick_sel;
                  busy_q          <= 1'b1;
                  state_q         <= LOAD;
               end
            end
            LOAD: begin
               ack_q        <= '0;
               tx_byte_en_q <= 1'b1;
               cnt_q        <= '0;
               state_q      <= FRAME;
            end
            FRAME: begin
               cnt_q <= cnt_q + 32'd1;
               if (cnt_q == 32'(EN_HOLD - 1))
                  tx_byte_en_q <= 1'b0;
               if (cnt_q == 32'(FRAME_CYCLES - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack        = ack_q;
   assign tx_byte_en = tx_byte_en_q;
   assign tx_byte    = tx_byte_q;
   assign busy       = busy_q;
   assign last_gnt   = last_gnt_q;

endmodule
